// File: rtl/prio_pkg.sv
// Shared constants and the wrapping descending priority search used by the
// request encoder. Optional grant counter is enabled by PRIO_GRANT_CNT_EN.
package prio_pkg;

  localparam int N_DEF = 16;
  localparam int N_MAX = 64;

  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } sel_t;

  // Scan from start downwards, wrapping from 0 to n-1; first eligible bit wins.
  function automatic sel_t prio_search(input logic [N_MAX-1:0] elig,
                                       input int unsigned start,
                                       input int unsigned n);
    sel_t res;
    int unsigned pos;
    res = '0;
    pos = 0;
    for (int unsigned i = 0; i < N_MAX; i++) begin
      if (i < n && !res.found) begin
        pos = (start >= i) ? start - i : start + n - i;
        if (elig[pos[5:0]]) begin
          res.found = 1'b1;
          res.idx   = pos[5:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/prio_req_encoder_if.sv
// Valid/ready grant channel carrying the selected request index.
interface prio_req_encoder_if #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
);
  logic             out_valid_o;
  logic             out_ready_i;
  logic [IDX_W-1:0] out_idx_o;

  modport master (output out_valid_o, output out_idx_o, input out_ready_i);
  modport slave  (input out_valid_o, input out_idx_o, output out_ready_i);
endinterface

// File: rtl/prio_rr_sel.sv
// Combinational selector: fixed priority starts at N-1, round-robin starts
// just below the last granted index.
module prio_rr_sel
  import prio_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  input  logic             rr_mode,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N_MAX-1:0] elig_ext;
  int unsigned      start;
  sel_t             res;

  always_comb begin
    elig_ext = N_MAX'(eligible);
    if (rr_mode && ptr != '0) start = 32'(ptr) - 32'd1;
    else                      start = 32'(N - 1);
    res   = prio_search(elig_ext, start, 32'(N));
    idx   = res.idx[IDX_W-1:0];
    found = res.found;
  end

endmodule

// File: rtl/prio_req_encoder.sv
// Registered priority request encoder: sticky pending bits, per-bit mask,
// fixed or round-robin selection. PRIO_GRANT_CNT_EN adds a saturating grant counter.
module prio_req_encoder
  import prio_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_i,
  input  logic [N-1:0]           mask_i,
  input  logic                   rr_mode_i,
  prio_req_encoder_if.master     grant,
  output logic [N-1:0]           pending_o
`ifdef PRIO_GRANT_CNT_EN
  ,
  input  logic                   cnt_clr_i,
  output logic [15:0]            grant_cnt_o
`endif
);

  logic             hs;
  logic             load;
  logic [N-1:0]     clr;
  logic [N-1:0]     eligible;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;

  assign hs   = grant.out_valid_o && grant.out_ready_i;
  assign load = !grant.out_valid_o || hs;
  assign clr  = hs ? (N'(1) << grant.out_idx_o) : '0;
  // The bit being handed over this cycle must not be presented again at once.
  assign eligible = pending_o & ~mask_i & ~clr;

  prio_rr_sel #(.N(N), .IDX_W(IDX_W)) u_sel (
    .eligible (eligible),
    .ptr      (ptr),
    .rr_mode  (rr_mode_i),
    .idx      (sel_idx),
    .found    (sel_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_o         <= '0;
      grant.out_valid_o <= 1'b0;
      grant.out_idx_o   <= '0;
      ptr               <= '0;
    end else begin
      pending_o <= (pending_o & ~clr) | req_i;
      if (hs) ptr <= grant.out_idx_o;
      if (load) begin
        grant.out_valid_o <= sel_found;
        if (sel_found) grant.out_idx_o <= sel_idx;
      end
    end
  end

`ifdef PRIO_GRANT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              grant_cnt_o <= '0;
    else if (cnt_clr_i)                      grant_cnt_o <= '0;
    else if (hs && grant_cnt_o != 16'hFFFF)  grant_cnt_o <= grant_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_prio_req_encoder.sv
// Bench for prio_req_encoder: directed scenarios plus random traffic against a
// behavioural model. Grant counter section builds only with PRIO_GRANT_CNT_EN.
module tb_prio_req_encoder;
  localparam int N  = 16;
  localparam int IW = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req, mask, pending;
  logic         rr_mode;
`ifdef PRIO_GRANT_CNT_EN
  logic         cnt_clr;
  logic [15:0]  grant_cnt;
`endif

  int passed = 0;
  int total  = 0;

  bit m_pend [N];
  bit m_valid;
  int m_idx;
  int m_ptr;

  prio_req_encoder_if #(.N(N), .IDX_W(IW)) bus ();

  prio_req_encoder #(.N(N), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .mask_i    (mask),
    .rr_mode_i (rr_mode),
    .grant     (bus.master),
    .pending_o (pending)
`ifdef PRIO_GRANT_CNT_EN
    ,
    .cnt_clr_i   (cnt_clr),
    .grant_cnt_o (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] model_pend_vec();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_pend[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
  endtask

  // One clock: apply inputs, advance the model across the edge, compare.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] m,
                      input bit mode, input bit rdy);
    bit hs;
    int best, bestd, d, old_idx;
    req = r; mask = m; rr_mode = mode; bus.out_ready_i = rdy;
    @(posedge clk);
    hs = m_valid && rdy;
    old_idx = m_idx;
    best = -1;
    bestd = N;
    for (int k = 0; k < N; k++) begin
      if (m_pend[k] && !m[k] && !(hs && k == old_idx)) begin
        // distance along the search order: rr starts at ptr-1 descending
        d = mode ? (m_ptr + N - 1 - k) % N : (N - 1 - k);
        if (d < bestd) begin bestd = d; best = k; end
      end
    end
    for (int k = 0; k < N; k++)
      m_pend[k] = (m_pend[k] && !(hs && k == old_idx)) || r[k];
    if (!m_valid || hs) begin
      if (best >= 0) begin m_valid = 1'b1; m_idx = best; end
      else m_valid = 1'b0;
    end
    if (hs) m_ptr = old_idx;
    #1;
    check("valid", 64'(bus.out_valid_o), 64'(m_valid));
    check("idx", 64'(bus.out_idx_o), 64'(m_idx));
    check("pending", 64'(pending), 64'(model_pend_vec()));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_idx", 64'(bus.out_idx_o), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int e4 [4];
    req = '0; mask = '0; rr_mode = 1'b0; bus.out_ready_i = 1'b0;
`ifdef PRIO_GRANT_CNT_EN
    cnt_clr = 1'b0;
`endif
    model_reset();
    do_reset();

    // idle after reset
    for (int i = 0; i < 10; i++) step('0, '0, 1'b0, 1'b1);

    // fixed priority drain of 16'h8421
    e4 = '{15, 10, 5, 0};
    step(16'h8421, '0, 1'b0, 1'b1);
    check("lat_valid", 64'(bus.out_valid_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step('0, '0, 1'b0, 1'b1);
      check("drain_idx", 64'(bus.out_idx_o), 64'(e4[i]));
      check("drain_valid", 64'(bus.out_valid_o), 64'd1);
    end
    step('0, '0, 1'b0, 1'b1);
    check("drain_end_valid", 64'(bus.out_valid_o), 64'd0);
    check("drain_end_pend", 64'(pending), 64'd0);

    // stall holds idx 4 while 15 arrives
    step(16'h0010, '0, 1'b0, 1'b0);
    step(16'h8000, '0, 1'b0, 1'b0);
    check("stall_idx0", 64'(bus.out_idx_o), 64'd4);
    step('0, 16'h0010, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    check("stall_idx2", 64'(bus.out_idx_o), 64'd4);
    step('0, '0, 1'b0, 1'b1);
    check("after_stall_idx", 64'(bus.out_idx_o), 64'd15);
    step('0, '0, 1'b0, 1'b1);

    // async reset in the middle of a stall
    step(16'h0040, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    check("prestall_idx", 64'(bus.out_idx_o), 64'd6);
    do_reset();

    // round-robin alternation on 16'h0101
    e4 = '{8, 0, 8, 0};
    step(16'h0101, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(16'h0101, '0, 1'b1, 1'b1);
      check("rr_idx", 64'(bus.out_idx_o), 64'(e4[i]));
    end
    for (int i = 0; i < 6; i++) begin
      step(16'h0101, 16'h0100, 1'b1, 1'b1);
      check("rr_mask_idx", 64'(bus.out_idx_o), 64'd0);
      check("rr_mask_pend8", 64'(pending[8]), 64'd1);
    end
    do_reset();

    // re-request of the bit being handed over
    step(16'h0008, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    step(16'h0008, '0, 1'b0, 1'b1);
    check("rereq_pend3", 64'(pending[3]), 64'd1);
    step('0, '0, 1'b0, 1'b1);
    check("rereq_valid", 64'(bus.out_valid_o), 64'd1);
    check("rereq_idx", 64'(bus.out_idx_o), 64'd3);
    step('0, '0, 1'b0, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r, m;
      r = N'($urandom & $urandom);
      m = N'($urandom & $urandom & $urandom);
      step(r, m, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

`ifdef PRIO_GRANT_CNT_EN
    do_reset();
    check("cnt_reset", 64'(grant_cnt), 64'd0);
    req = '1; mask = '0; rr_mode = 1'b0; bus.out_ready_i = 1'b1;
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    check("cnt_sat", 64'(grant_cnt), 64'hFFFF);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    check("cnt_clr_valid", 64'(bus.out_valid_o), 64'd1);
    check("cnt_clr", 64'(grant_cnt), 64'd0);
    cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    check("cnt_inc", 64'(grant_cnt), 64'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
